// File: rtl/alarm_pkg.sv
// -----------------------------------------------------------------------------
// alarm_pkg
// Shared definitions for the alarm snooze controller.
//   alarm_state_t : controller FSM states (IDLE, RINGING, SNOOZE)
//   SECS_PER_MIN  : seconds per minute, used to size and load the snooze timer
// -----------------------------------------------------------------------------
package alarm_pkg;
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RINGING = 2'd1,
      SNOOZE  = 2'd2
   } alarm_state_t;

   localparam int SECS_PER_MIN = 60;
endpackage

// File: rtl/key_edge.sv
// -----------------------------------------------------------------------------
// key_edge
// Rising-edge detector for an already debounced key level.
//   clk   : system clock
//   reset : asynchronous active-high reset (history cleared to 0)
//   key   : debounced key level
//   rise  : high for the cycle in which key is high and was low last cycle
// -----------------------------------------------------------------------------
module key_edge (
   input  logic clk,
   input  logic reset,
   input  logic key,
   output logic rise
);
   logic key_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) key_q <= 1'b0;
      else       key_q <= key;
   end

   assign rise = key & ~key_q;
endmodule

// File: rtl/alarm_snooze_controller.sv
// -----------------------------------------------------------------------------
// alarm_snooze_controller
// Ring / snooze / stop sequencing for an alarm clock. Sits beside an external
// alarm detector: clears it with stop_alarm and re-triggers it with snooze_eq.
//   clk, reset     : clock, asynchronous active-high reset
//   one_sec_tick   : one-cycle pulse per second
//   alarm_light    : latched alarm from the detector
//   snooze_key     : debounced level, acts on rising edge
//   stop_key       : debounced level, acts on rising edge
//   stop_alarm     : one-cycle clear pulse to the detector
//   snooze_eq      : one-cycle re-trigger pulse to the detector
//   buzzer         : buzzer drive (high only while RINGING)
//   snooze_active  : high in SNOOZE
//   snoozes_left   : snoozes remaining for the current alarm event
// Build option: ALARM_BUZZER_PULSE_EN -- buzzer toggles each second while
// RINGING (starting high); otherwise it is steady high while RINGING.
// -----------------------------------------------------------------------------
module alarm_snooze_controller
   import alarm_pkg::*;
#(
   parameter int SNOOZE_MIN       = 5,
   parameter int MAX_SNOOZES      = 3,
   parameter int RING_TIMEOUT_SEC = 60
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       one_sec_tick,
   input  logic       alarm_light,
   input  logic       snooze_key,
   input  logic       stop_key,
   output logic       stop_alarm,
   output logic       snooze_eq,
   output logic       buzzer,
   output logic       snooze_active,
   output logic [2:0] snoozes_left
);
   localparam int SNZ_LOAD = SNOOZE_MIN * SECS_PER_MIN;
   localparam int SNZ_W    = $clog2(SNZ_LOAD + 1);
   localparam logic [SNZ_W-1:0] SNZ_LOAD_V = SNZ_W'(SNZ_LOAD);
   localparam logic [2:0]       MAX_V      = 3'(MAX_SNOOZES);
   localparam logic [8:0]       RTO_V      = 9'(RING_TIMEOUT_SEC);

   alarm_state_t     state;
   logic [SNZ_W-1:0] snz_cnt;
   logic [7:0]       ring_cnt;
   logic             snz_rise, stop_rise;
   logic             stop_req, snz_req, ext_clr, expire, timeout;

   key_edge u_snz_edge  (.clk(clk), .reset(reset), .key(snooze_key), .rise(snz_rise));
   key_edge u_stop_edge (.clk(clk), .reset(reset), .key(stop_key),   .rise(stop_rise));

   // This tick brings the ring counter to the timeout value.
   assign timeout = one_sec_tick && (({1'b0, ring_cnt} + 9'd1) >= RTO_V);

   // Decide this cycle's transition. Priority: stop, snooze key, external
   // clear, timeout/expiry. Snooze with none left degrades to stop.
   always_comb begin
      stop_req = 1'b0;
      snz_req  = 1'b0;
      ext_clr  = 1'b0;
      expire   = 1'b0;
      unique case (state)
         RINGING: begin
            if (stop_rise)     stop_req = 1'b1;
            else if (snz_rise) snz_req  = 1'b1;
            // The detector re-latches one cycle after snooze_eq, so the
            // still-low alarm_light in that first RINGING cycle is expected.
            else if (!alarm_light && !snooze_eq) ext_clr = 1'b1;
            else if (timeout)  snz_req  = 1'b1;
         end
         SNOOZE: begin
            if (stop_rise) stop_req = 1'b1;
            else if (one_sec_tick && snz_cnt <= SNZ_W'(1)) expire = 1'b1;
         end
         default: ;
      endcase
      if (snz_req && snoozes_left == 3'd0) begin
         snz_req  = 1'b0;
         stop_req = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         snz_cnt       <= '0;
         ring_cnt      <= '0;
         stop_alarm    <= 1'b0;
         snooze_eq     <= 1'b0;
         buzzer        <= 1'b0;
         snooze_active <= 1'b0;
         snoozes_left  <= MAX_V;
      end else begin
         stop_alarm <= 1'b0;
         snooze_eq  <= 1'b0;
         if (stop_req || ext_clr) begin
            state         <= IDLE;
            stop_alarm    <= stop_req;
            snoozes_left  <= MAX_V;
            snz_cnt       <= '0;
            ring_cnt      <= '0;
            buzzer        <= 1'b0;
            snooze_active <= 1'b0;
         end else if (snz_req) begin
            state         <= SNOOZE;
            stop_alarm    <= 1'b1;
            snoozes_left  <= snoozes_left - 3'd1;
            snz_cnt       <= SNZ_LOAD_V;
            ring_cnt      <= '0;
            buzzer        <= 1'b0;
            snooze_active <= 1'b1;
         end else if (expire) begin
            state         <= RINGING;
            snooze_eq     <= 1'b1;
            snz_cnt       <= '0;
            ring_cnt      <= '0;
            buzzer        <= 1'b1;
            snooze_active <= 1'b0;
         end else begin
            unique case (state)
               IDLE: begin
                  // alarm_light is still high in the cycle our own clear
                  // pulse is out; don't re-ring on that stale value.
                  if (alarm_light && !stop_alarm) begin
                     state    <= RINGING;
                     ring_cnt <= '0;
                     buzzer   <= 1'b1;
                  end
               end
               RINGING: begin
                  if (one_sec_tick) begin
                     ring_cnt <= ring_cnt + 8'd1;
`ifdef ALARM_BUZZER_PULSE_EN
                     buzzer <= ~buzzer;
`else
                     buzzer <= 1'b1;
`endif
                  end
               end
               SNOOZE: begin
                  if (one_sec_tick && snz_cnt != '0) snz_cnt <= snz_cnt - SNZ_W'(1);
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_alarm_snooze_controller.sv
// -----------------------------------------------------------------------------
// tb_alarm_snooze_controller
// Scoreboard bench: each expected stop_alarm / snooze_eq pulse (with the
// snoozes_left / snooze_active / buzzer values it should carry) is queued when
// the stimulus is driven and checked when the pulse appears. A small model of
// the external alarm detector drives alarm_light.
// -----------------------------------------------------------------------------
module tb_alarm_snooze_controller;
   localparam int SNOOZE_MIN = 1;
   localparam int MAX_SNZ    = 3;
   localparam int RTO        = 10;
`ifdef ALARM_BUZZER_PULSE_EN
   localparam bit PULSE = 1'b1;
`else
   localparam bit PULSE = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       one_sec_tick, alarm_light, snooze_key, stop_key;
   logic       stop_alarm, snooze_eq, buzzer, snooze_active;
   logic [2:0] snoozes_left;
   logic       al_set, al_clr;

   typedef struct {
      int    kind;   // 0 = stop_alarm, 1 = snooze_eq
      int    left;
      int    active;
      int    buzz;
      string tag;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int   n_tests = 0;
   int   n_fail  = 0;
   logic stop_q = 1'b0, eq_q = 1'b0;

   always #5 clk = ~clk;

   alarm_snooze_controller #(
      .SNOOZE_MIN(SNOOZE_MIN), .MAX_SNOOZES(MAX_SNZ), .RING_TIMEOUT_SEC(RTO)
   ) dut (
      .clk(clk), .reset(rst), .one_sec_tick(one_sec_tick),
      .alarm_light(alarm_light), .snooze_key(snooze_key), .stop_key(stop_key),
      .stop_alarm(stop_alarm), .snooze_eq(snooze_eq), .buzzer(buzzer),
      .snooze_active(snooze_active), .snoozes_left(snoozes_left)
   );

   // External detector: latched alarm, cleared by stop_alarm, set by snooze_eq.
   always @(posedge clk or posedge rst) begin
      if (rst)                       alarm_light <= 1'b0;
      else if (stop_alarm || al_clr) alarm_light <= 1'b0;
      else if (snooze_eq || al_set)  alarm_light <= 1'b1;
   end

   task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d want %0d", tag, act, exp);
      end
   endtask

   // Scoreboard side: every pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (!rst) begin
         if (stop_alarm || snooze_eq) begin
            chk("pulse_excl", 32'(stop_alarm & snooze_eq), 0);
            chk("pulse_width", 32'((stop_alarm & stop_q) | (snooze_eq & eq_q)), 0);
            if (q.size() == 0) chk("unexpected_pulse", 32'({stop_alarm, snooze_eq}), 0);
            else begin
               e = q.pop_front();
               chk({e.tag, "_kind"},   32'(snooze_eq),     e.kind);
               chk({e.tag, "_left"},   32'(snoozes_left),  e.left);
               chk({e.tag, "_active"}, 32'(snooze_active), e.active);
               chk({e.tag, "_buzz"},   32'(buzzer),        e.buzz);
            end
         end
         stop_q = stop_alarm;
         eq_q   = snooze_eq;
      end else begin
         stop_q = 1'b0;
         eq_q   = 1'b0;
      end
   end

   task automatic push(int kind, int left, int active, int buzz, string tag);
      exp_t x;
      x.kind = kind; x.left = left; x.active = active; x.buzz = buzz; x.tag = tag;
      q.push_back(x);
   endtask

   task automatic cyc(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic tick_n(int n);
      repeat (n) begin
         @(posedge clk); #1 one_sec_tick = 1'b1;
         @(posedge clk); #1 one_sec_tick = 1'b0;
      end
   endtask

   task automatic press(bit s, bit t);
      @(posedge clk); #1 snooze_key = s; stop_key = t;
      @(posedge clk); #1 snooze_key = 1'b0; stop_key = 1'b0;
   endtask

   // Detector latches on the first edge, controller rings on the second.
   task automatic trigger();
      @(posedge clk); #1 al_set = 1'b1;
      @(posedge clk); #1 al_set = 1'b0;
      cyc(1);
   endtask

   initial begin
      rst = 1'b1; one_sec_tick = 1'b0; snooze_key = 1'b0; stop_key = 1'b0;
      al_set = 1'b0; al_clr = 1'b0;
      cyc(3);
      chk("rst_left",   32'(snoozes_left),  3);
      chk("rst_active", 32'(snooze_active), 0);
      chk("rst_buzz",   32'(buzzer),        0);
      chk("rst_stop",   32'(stop_alarm),    0);
      chk("rst_eq",     32'(snooze_eq),     0);
      rst = 1'b0;
      cyc(2);

      // Plain ring then stop.
      trigger();
      cyc(2);
      chk("ring_buzz",   32'(buzzer),        1);
      chk("ring_active", 32'(snooze_active), 0);
      push(0, 3, 0, 0, "stop");
      press(1'b0, 1'b1);
      cyc(2);
      chk("stop_buzz", 32'(buzzer),       0);
      chk("stop_left", 32'(snoozes_left), 3);

      // Buzzer modulation across ticks.
      trigger();
      chk("bz_t0", 32'(buzzer), 1);
      tick_n(1);
      chk("bz_t1", 32'(buzzer), PULSE ? 0 : 1);
      tick_n(1);
      chk("bz_t2", 32'(buzzer), 1);
      push(0, 3, 0, 0, "bz_stop");
      press(1'b0, 1'b1);

      // Snooze, expiry after exactly 60 ticks, then exhaust the snoozes.
      trigger();
      push(0, 2, 1, 0, "snz1");
      press(1'b1, 1'b0);
      chk("snz1_active", 32'(snooze_active), 1);
      tick_n(59);
      chk("snz1_early", q.size(), 0);
      push(1, 2, 0, 1, "eq1");
      tick_n(1);
      cyc(2);
      chk("eq1_ring", 32'(buzzer), 1);
      push(0, 1, 1, 0, "snz2");
      press(1'b1, 1'b0);
      tick_n(59);
      push(1, 1, 0, 1, "eq2");
      tick_n(1);
      cyc(2);
      push(0, 0, 1, 0, "snz3");
      press(1'b1, 1'b0);
      tick_n(59);
      push(1, 0, 0, 1, "eq3");
      tick_n(1);
      cyc(2);
      push(0, 3, 0, 0, "exhaust");
      press(1'b1, 1'b0);
      cyc(1);
      chk("exhaust_left", 32'(snoozes_left), 3);
      chk("exhaust_buzz", 32'(buzzer),       0);

      // Unattended ring auto-snoozes on the timeout tick.
      trigger();
      tick_n(RTO - 1);
      chk("to_early", q.size(), 0);
      push(0, 2, 1, 0, "timeout");
      tick_n(1);
      chk("to_active", 32'(snooze_active), 1);
      press(1'b1, 1'b0);          // ignored in SNOOZE
      cyc(2);
      chk("snz_ign_left", 32'(snoozes_left), 2);
      push(0, 3, 0, 0, "snz_stop");
      press(1'b0, 1'b1);

      // Stop and snooze together: stop wins.
      trigger();
      push(0, 3, 0, 0, "both");
      press(1'b1, 1'b1);
      cyc(1);
      chk("both_left",   32'(snoozes_left),  3);
      chk("both_active", 32'(snooze_active), 0);

      // External detector clear while re-ringing reloads the snoozes.
      trigger();
      push(0, 2, 1, 0, "snz_ext");
      press(1'b1, 1'b0);
      tick_n(59);
      push(1, 2, 0, 1, "eq_ext");
      tick_n(1);
      cyc(3);
      chk("ext_ring", 32'(buzzer), 1);
      @(posedge clk); #1 al_clr = 1'b1;
      @(posedge clk); #1 al_clr = 1'b0;
      cyc(1);
      chk("ext_buzz",   32'(buzzer),        0);
      chk("ext_left",   32'(snoozes_left),  3);
      chk("ext_active", 32'(snooze_active), 0);

      // Reset mid-snooze drops the pending re-trigger.
      trigger();
      push(0, 2, 1, 0, "snz_rst");
      press(1'b1, 1'b0);
      tick_n(30);
      rst = 1'b1;
      cyc(2);
      chk("mid_rst_left",   32'(snoozes_left),  3);
      chk("mid_rst_active", 32'(snooze_active), 0);
      rst = 1'b0;
      tick_n(70);
      chk("post_rst_buzz",   32'(buzzer),        0);
      chk("post_rst_active", 32'(snooze_active), 0);

      cyc(2);
      chk("queue_drained", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
